// File: rtl/encoder_rr_arbiter_pkg.sv
// Shared definitions for the 7-way round-robin arbiter.
//   N_REQ / ID_W    : requester count and owner-code width
//   arb_state_t     : FSM state encoding
//   NO_OWNER        : owner code meaning "nobody holds the resource"
//   first_set_code  : code (i+1) of the lowest set bit, NO_OWNER if none
package encoder_rr_arbiter_pkg;

    localparam int N_REQ = 7;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam logic [ID_W-1:0] NO_OWNER = 3'd0;

    function automatic logic [ID_W-1:0] first_set_code(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] code;
        code = NO_OWNER;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) code = ID_W'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/encoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req     : request vector, bit i = requester i
//   done    : owner release strobe
//   gnt     : one-hot registered grant
//   gnt_id  : encoded owner (i+1), 0 when idle
//   busy    : resource currently owned
//   timeout : one-cycle pulse when the hold limit revoked a grant
// master = requester side, slave = arbiter side.
interface encoder_rr_arbiter_if;
    import encoder_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );

endinterface

// File: rtl/encoder_rr_arbiter_rr_pick7.sv
// Combinational round-robin pick for 7 requesters.
//   req    in  7 : request vector
//   last   in  3 : index (0..6) of the previous owner
//   winner out 7 : one-hot winner, zero if no request
//   code   out 3 : winner code (i+1), 0 if no request
module rr_pick7
    import encoder_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] winner,
    output logic [ID_W-1:0]  code
);

    logic [N_REQ-1:0] above_last;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pool;

    // Requests strictly above the previous owner take precedence; when there
    // are none the search wraps and the raw vector is used instead.
    always_comb begin
        above_last = '0;
        for (int i = 0; i < N_REQ; i++) begin
            above_last[i] = (ID_W'(i) > last);
        end
        masked = req & above_last;
        pool   = (|masked) ? masked : req;
        code   = first_set_code(pool);
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            winner[i] = (code == ID_W'(i + 1));
        end
    end

endmodule

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter sharing one downstream slot among 7 requesters.
// Grants are registered, held until released, and revoked after HOLD_MAX
// consecutive cycles (HOLD_MAX = 0 disables the limit). Every release is
// followed by one dead cycle so two owners never overlap.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : encoder_rr_arbiter_if.slave (req, done in; gnt, gnt_id, busy, timeout out)
// Parameters: HOLD_MAX (limit), CNT_W (hold counter width, 2**CNT_W > HOLD_MAX).
//
// state | meaning
// IDLE  | no owner, arbitrate on any request
// GRANT | one owner holds the slot, hold counter running
// GAP   | single dead cycle after a release, arbitrate for the next owner
module encoder_rr_arbiter
    import encoder_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_rr_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_code;
    logic             owner_req;
    logic             limit_hit;
    logic             release_now;

    rr_pick7 u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (win_onehot),
        .code   (win_code)
    );

    // gnt_q is one-hot on the owner, so this is req[owner].
    assign owner_req   = |(bus.req & gnt_q);
    assign limit_hit   = (HOLD_MAX != 0) && (hold_q == HOLD_LIM);
    assign release_now = bus.done || !owner_req || limit_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= NO_OWNER;
            last_q    <= ID_W'(N_REQ - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    gnt_d   = win_onehot;
                    id_d    = win_code;
                    hold_d  = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = NO_OWNER;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    id_d      = NO_OWNER;
                    last_d    = id_q - ID_W'(1);
                    hold_d    = '0;
                    // Only a pure limit release is flagged; done takes priority.
                    timeout_d = !bus.done && owner_req;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = NO_OWNER;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = (state_q == GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
module tb_encoder_rr_arbiter;
    import encoder_rr_arbiter_pkg::*;

    localparam int HM = 4;

    typedef struct packed {
        logic [6:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    encoder_rr_arbiter_if bus();

    encoder_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Reference: circular search starting just after the previous owner.
    function automatic int rr_next(input logic [6:0] r, input int last);
        for (int k = 1; k <= 7; k++) begin
            if (r[(last + k) % 7]) return (last + k) % 7;
        end
        return -1;
    endfunction

    // Behavioural model: phase 0 idle, 1 owned, 2 dead cycle after a release.
    int   m_phase = 0;
    int   m_owner = -1;
    int   m_last  = 6;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    initial begin
        exp_t e;
        logic own_req;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_owner = -1; m_last = 6; m_hold = 0; m_to = 1'b0;
            end else if (m_phase == 1) begin
                own_req = bus.req[m_owner];
                if (bus.done || !own_req || (HM != 0 && m_hold == HM)) begin
                    m_to    = !bus.done && own_req;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_phase = 2;
                    m_hold  = 0;
                end else begin
                    m_hold++;
                end
            end else begin
                m_to = 1'b0;
                if (bus.req != 7'd0) begin
                    m_owner = rr_next(bus.req, m_last);
                    m_phase = 1;
                    m_hold  = 1;
                end else begin
                    m_phase = 0;
                end
            end
            e.gnt  = (m_owner >= 0) ? 7'(1 << m_owner) : 7'd0;
            e.id   = 3'(m_owner + 1);
            e.busy = (m_owner >= 0);
            e.to   = m_to;
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents a fresh output set, compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", 32'(bus.gnt), 32'(e.gnt));
                check("gnt_id", 32'(bus.gnt_id), 32'(e.id));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("timeout", 32'(bus.timeout), 32'(e.to));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int budget;
        budget = 20;
        while (!bus.busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.busy) check({name, "_wait_busy"}, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        int seen[$];
        int run;
        rst      = 1'b1;
        bus.req  = 7'd0;
        bus.done = 1'b0;
        tick(2);
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // No requests.
        tick(20);
        check("idle_gnt_id", 32'(bus.gnt_id), 32'd0);

        // Rotation with done pulsed in each grant.
        bus.req = 7'b1010001;
        for (int k = 0; k < 4; k++) begin
            wait_busy("rotate");
            seen.push_back(int'(bus.gnt_id));
            bus.done = 1'b1;
            tick(1);
            bus.done = 1'b0;
            check("rotate_gap", 32'(bus.gnt), 32'd0);
        end
        if (seen.size() == 4) begin
            check("rotate_0", 32'(seen[0]), 32'd1);
            check("rotate_1", 32'(seen[1]), 32'd5);
            check("rotate_2", 32'(seen[2]), 32'd7);
            check("rotate_3", 32'(seen[3]), 32'd1);
        end else begin
            check("rotate_count", 32'(seen.size()), 32'd4);
        end
        bus.req = 7'd0;
        tick(3);

        // Hold limit with a sole requester.
        bus.req = 7'b0000010;
        wait_busy("limit");
        run = 0;
        while (bus.busy && run < 20) begin
            check("limit_id", 32'(bus.gnt_id), 32'd2);
            run++;
            tick(1);
        end
        check("limit_len", 32'(run), 32'(HM));
        check("limit_pulse", 32'(bus.timeout), 32'd1);
        tick(1);
        check("limit_regrant", 32'(bus.gnt_id), 32'd2);
        check("limit_pulse_end", 32'(bus.timeout), 32'd0);
        bus.req = 7'd0;
        tick(3);

        // Owner drops its request.
        bus.req = 7'b0001000;
        wait_busy("drop");
        check("drop_id", 32'(bus.gnt_id), 32'd4);
        tick(1);
        bus.req = 7'd0;
        tick(1);
        check("drop_gnt", 32'(bus.gnt), 32'd0);
        check("drop_timeout", 32'(bus.timeout), 32'd0);
        tick(2);

        // done coincides with the hold limit.
        bus.req = 7'b0000100;
        wait_busy("coincide");
        tick(HM - 1);
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        check("coincide_busy", 32'(bus.busy), 32'd0);
        check("coincide_timeout", 32'(bus.timeout), 32'd0);
        bus.req = 7'd0;
        tick(3);

        // Asynchronous reset mid-grant.
        bus.req = 7'b0100000;
        wait_busy("rst_mid");
        check("rst_mid_id", 32'(bus.gnt_id), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_gnt", 32'(bus.gnt), 32'd0);
        check("rst_async_id", 32'(bus.gnt_id), 32'd0);
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        tick(2);
        bus.req = 7'b1111111;
        rst = 1'b0;
        wait_busy("after_rst");
        check("after_rst_id", 32'(bus.gnt_id), 32'd1);
        bus.req = 7'd0;
        tick(3);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 7'($urandom_range(0, 127));
            bus.done = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        bus.req  = 7'd0;
        bus.done = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
